vip_sample_assembler: RTL and testbench

- Receive-side counterpart of the clocked-video-output sample counter: rebuilds full parallel pixel samples from incoming colour-plane symbols.
- SD mode (hd_sdn=0): planes arrive one symbol per beat and are packed into one parallel sample.
- HD mode (hd_sdn=1): all planes arrive in parallel in one beat and pass straight through.
- Sits between the clocked-video-input sync/symbol front end and the Avalon-ST pixel path; presents a one-entry valid/ready output stage.

---
 rtl/vip_sample_assembler.sv | 125 ++++++++++++
 tb/tb_vip_sample_assembler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/vip_sample_assembler.sv
// -----------------------------------------------------------------------------
// vip_sample_assembler
//
// Builds complete parallel pixel samples from incoming colour-plane symbols.
// This is the receive-side partner of the clocked-video-output sample counter.
//
//   SD mode (hd_sdn = 0): one plane symbol arrives per beat in
//                         in_data[BPS-1:0]. The symbols are packed into one
//                         sample, with plane 0 in the LSBs.
//   HD mode (hd_sdn = 1): all planes arrive together in one beat and pass
//                         straight through to the output.
//
// Ports
//   clk             rising-edge clock for all logic
//   rst             synchronous, active-high reset
//   sclr            synchronous realign; throws away any partial sample
//   hd_sdn          1 = planes in parallel, 0 = planes sequential
//   in_valid/ready  input beat handshake
//   in_data         input symbol (SD) or full sample (HD)
//   out_valid/ready one-entry output stage handshake
//   out_data        assembled sample, plane 0 in LSBs
//   start_of_sample the next accepted beat begins a new sample
//   sample_ticks    plane index that the next SD beat will fill
// -----------------------------------------------------------------------------
module vip_sample_assembler #(
    parameter int BPS                          = 8,
    parameter int NUMBER_OF_COLOUR_PLANES      = 3,
    parameter int LOG2_NUMBER_OF_COLOUR_PLANES = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    sclr,
    input  logic                                    hd_sdn,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [BPS*NUMBER_OF_COLOUR_PLANES-1:0]  in_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [BPS*NUMBER_OF_COLOUR_PLANES-1:0]  out_data,
    output logic                                    start_of_sample,
    output logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] sample_ticks
);

    localparam int N     = NUMBER_OF_COLOUR_PLANES;
    localparam int L     = LOG2_NUMBER_OF_COLOUR_PLANES;
    localparam int W     = BPS * N;
    // The accumulator holds planes 0..N-2. It is kept at least one symbol wide
    // so that N = 1 still elaborates.
    localparam int ACC_W = (N > 1) ? BPS * (N - 1) : BPS;
    localparam logic [L-1:0] LAST_PLANE = L'(N - 1);

    logic [L-1:0]     cnt;
    logic [L-1:0]     eff_cnt;
    logic [ACC_W-1:0] accum;
    logic [W-1:0]     sd_sample;
    logic             completing;
    logic             accept;

    // sclr realigns in the same cycle, so the beat that arrives with it is
    // treated as plane 0.
    assign eff_cnt    = sclr ? '0 : cnt;
    assign completing = hd_sdn || (N == 1) || (eff_cnt == LAST_PLANE);

    // Only a completing beat needs room in the output stage. Partial beats are
    // always taken, so accumulation never stalls.
    assign in_ready   = completing ? (!out_valid || out_ready) : 1'b1;
    assign accept     = in_valid && in_ready;

    generate
        if (N > 1) begin : g_multi_plane
            assign sd_sample = {in_data[BPS-1:0], accum[BPS*(N-1)-1:0]};
        end else begin : g_single_plane
            assign sd_sample = in_data;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            // A completing beat that lands on the same edge as a consume
            // reloads the stage, so out_valid stays high with no bubble.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && completing) begin
                out_valid <= 1'b1;
                out_data  <= hd_sdn ? in_data : sd_sample;
            end
        end
    end

    // In HD mode the counter is pinned to 0. This drops any SD partial that
    // was in progress when the mode switched.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (hd_sdn || (accept && completing)) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= eff_cnt + 1'b1;
        end else if (sclr) begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            accum <= '0;
        end else begin
            for (int k = 0; k < N - 1; k++) begin
                if (accept && !completing && (eff_cnt == L'(k))) begin
                    accum[k*BPS +: BPS] <= in_data[BPS-1:0];
                end else if (sclr || hd_sdn) begin
                    accum[k*BPS +: BPS] <= '0;
                end
            end
        end
    end

    assign start_of_sample = hd_sdn || (cnt == '0);
    assign sample_ticks    = cnt;

endmodule

// File: tb/tb_vip_sample_assembler.sv
// -----------------------------------------------------------------------------
// tb_vip_sample_assembler
//
// Drives vip_sample_assembler with directed and random beats. A reference
// model compares every output. The model keeps the partial sample as a queue
// of plane symbols, plus one register for the pending output sample.
// -----------------------------------------------------------------------------
module tb_vip_sample_assembler;

    localparam int BPS = 8;
    localparam int N   = 3;
    localparam int L   = 2;
    localparam int W   = BPS * N;

    logic         clk;
    logic         rst;
    logic         sclr;
    logic         hd_sdn;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         start_of_sample;
    logic [L-1:0] sample_ticks;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [BPS-1:0] part[$];
    logic           m_valid;
    logic [W-1:0]   m_data;

    vip_sample_assembler #(
        .BPS                          (BPS),
        .NUMBER_OF_COLOUR_PLANES      (N),
        .LOG2_NUMBER_OF_COLOUR_PLANES (L)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sclr            (sclr),
        .hd_sdn          (hd_sdn),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .start_of_sample (start_of_sample),
        .sample_ticks    (sample_ticks)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Applies one cycle of inputs and checks in_ready before the clock edge.
    // It then advances the model and checks the registered outputs after the
    // edge. Both the call and the return happen on a falling edge.
    task automatic applyStimulus(input logic r, input logic s, input logic h,
                                 input logic v, input logic [W-1:0] d,
                                 input logic ordy);
        int       eff;
        bit       comp;
        bit       exp_ready;
        bit       acc;
        logic [W-1:0] sample;
        rst = r; sclr = s; hd_sdn = h; in_valid = v; in_data = d;
        out_ready = ordy;
        #1;
        eff       = s ? 0 : part.size();
        comp      = h || (N == 1) || (eff == N - 1);
        exp_ready = comp ? (!m_valid || ordy) : 1'b1;
        checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));

        if (r) begin
            part.delete();
            m_valid = 1'b0;
            m_data  = '0;
        end else begin
            if (s || h) part.delete();
            acc = v && exp_ready;
            if (m_valid && ordy) m_valid = 1'b0;
            if (acc) begin
                if (h) begin
                    m_data  = d;
                    m_valid = 1'b1;
                end else if (part.size() == N - 1) begin
                    sample = '0;
                    for (int k = 0; k < N - 1; k++) sample[k*BPS +: BPS] = part[k];
                    sample[(N-1)*BPS +: BPS] = d[BPS-1:0];
                    m_data  = sample;
                    m_valid = 1'b1;
                    part.delete();
                end else begin
                    part.push_back(d[BPS-1:0]);
                end
            end
        end

        @(posedge clk);
        @(negedge clk);
        checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
        checkOutput("out_data", 32'(out_data), 32'(m_data));
        checkOutput("sample_ticks", 32'(sample_ticks), 32'(part.size()));
        checkOutput("start_of_sample", 32'(start_of_sample),
                    32'(hd_sdn || (part.size() == 0)));
    endtask

    initial begin
        logic r, s, h, v, o;
        logic [W-1:0] d;
        rst = 1'b1; sclr = 1'b0; hd_sdn = 1'b0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b1;
        m_valid = 1'b0; m_data = '0;
        @(negedge clk);
        applyStimulus(1, 0, 0, 0, '0, 1);
        applyStimulus(1, 0, 0, 0, '0, 1);

        // SD pack of three symbols, with junk in the ignored upper bits
        applyStimulus(0, 0, 0, 1, 24'hFFFF11, 1);
        applyStimulus(0, 0, 0, 1, 24'h000022, 1);
        applyStimulus(0, 0, 0, 1, 24'h000033, 1);
        checkOutput("tp1_sample", 32'(out_data), 32'h332211);
        applyStimulus(0, 0, 0, 0, '0, 1);

        // HD back-to-back
        applyStimulus(0, 0, 1, 1, 24'hAABBCC, 1);
        applyStimulus(0, 0, 1, 1, 24'h010203, 1);
        checkOutput("tp2_second", 32'(out_data), 32'h010203);
        applyStimulus(0, 0, 1, 0, '0, 1);

        // SD backpressure with one sample pending
        applyStimulus(0, 0, 0, 1, 24'h000001, 1);
        applyStimulus(0, 0, 0, 1, 24'h000002, 1);
        applyStimulus(0, 0, 0, 1, 24'h000003, 0);
        applyStimulus(0, 0, 0, 1, 24'h000004, 0);
        applyStimulus(0, 0, 0, 1, 24'h000005, 0);
        applyStimulus(0, 0, 0, 1, 24'h000006, 0);
        applyStimulus(0, 0, 0, 1, 24'h000006, 0);
        applyStimulus(0, 0, 0, 1, 24'h000006, 1);
        checkOutput("tp3_reload", 32'(out_data), 32'h060504);
        applyStimulus(0, 0, 0, 0, '0, 1);

        // sclr realign
        applyStimulus(0, 0, 0, 1, 24'h000011, 1);
        applyStimulus(0, 0, 0, 1, 24'h000022, 1);
        applyStimulus(0, 1, 0, 1, 24'h000044, 1);
        applyStimulus(0, 0, 0, 1, 24'h000055, 1);
        applyStimulus(0, 0, 0, 1, 24'h000066, 1);
        checkOutput("tp4_sample", 32'(out_data), 32'h665544);

        // rst with cnt=2 and a pending sample
        applyStimulus(0, 0, 0, 1, 24'h000077, 0);
        applyStimulus(0, 0, 0, 1, 24'h000088, 0);
        applyStimulus(0, 0, 0, 1, 24'h000099, 0);
        applyStimulus(1, 0, 0, 0, '0, 0);
        checkOutput("tp5_out_data", 32'(out_data), 32'h0);

        // Mode switch to HD mid-sample
        applyStimulus(0, 0, 0, 1, 24'h0000EE, 1);
        applyStimulus(0, 0, 1, 1, 24'h0A0B0C, 1);
        checkOutput("tp6_sample", 32'(out_data), 32'h0A0B0C);
        applyStimulus(0, 0, 0, 1, 24'h000001, 1);

        // Random traffic
        h = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) h = ~h;
            v = ($urandom_range(0, 3) != 0);
            o = ($urandom_range(0, 2) != 0);
            d = W'($urandom);
            applyStimulus(r, s, h, v, d, o);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
